// File: rtl/ysyx_23060096_rf_wb_scheduler_if.sv
// Issue, write-back and register-file write bundle of the write-back scheduler.
// The slave side is the scheduler; the master side drives decode/EXU/LSU.
interface ysyx_23060096_rf_wb_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREG       = 32
);
  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic [ADDR_WIDTH-1:0] issue_rs1;
  logic [ADDR_WIDTH-1:0] issue_rs2;
  logic                  issue_stall;

  logic                  wb0_valid;
  logic [ADDR_WIDTH-1:0] wb0_rd;
  logic [DATA_WIDTH-1:0] wb0_data;
  logic                  wb0_ready;

  logic                  wb1_valid;
  logic [ADDR_WIDTH-1:0] wb1_rd;
  logic [DATA_WIDTH-1:0] wb1_data;
  logic                  wb1_ready;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [NREG-1:0]       busy_vec;

  modport slave (
    input  issue_valid, issue_rd, issue_rs1, issue_rs2,
    input  wb0_valid, wb0_rd, wb0_data,
    input  wb1_valid, wb1_rd, wb1_data,
    output issue_stall, wb0_ready, wb1_ready,
    output rf_wen, rf_waddr, rf_wdata, busy_vec
  );

  modport master (
    output issue_valid, issue_rd, issue_rs1, issue_rs2,
    output wb0_valid, wb0_rd, wb0_data,
    output wb1_valid, wb1_rd, wb1_data,
    input  issue_stall, wb0_ready, wb1_ready,
    input  rf_wen, rf_waddr, rf_wdata, busy_vec
  );
endinterface

// File: rtl/ysyx_23060096_rf_wb_scheduler.sv
// Round-robin arbiter of EXU/LSU write-backs onto the single RF write port,
// plus a busy scoreboard that stalls issue on RAW/WAW hazards.
module ysyx_23060096_rf_wb_scheduler #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREG       = 32
) (
  input logic clk,
  input logic rst,
  ysyx_23060096_rf_wb_scheduler_if.slave bus
);

  logic                  rr_q, rr_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  logic grant0, grant1, stall, accept;

  // rr_q holds the last granted index; on a tie the other requester wins
  always_comb begin
    grant0 = bus.wb0_valid & (~bus.wb1_valid | rr_q);
    grant1 = bus.wb1_valid & (~bus.wb0_valid | ~rr_q);
    stall  = bus.issue_valid &
             (((bus.issue_rs1 != '0) & busy_q[bus.issue_rs1]) |
              ((bus.issue_rs2 != '0) & busy_q[bus.issue_rs2]) |
              ((bus.issue_rd  != '0) & busy_q[bus.issue_rd]));
    accept = bus.issue_valid & ~stall;
  end

  always_comb begin
    rr_d       = rr_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    busy_d     = busy_q;

    if (grant0) begin
      rr_d = 1'b0;
      if (bus.wb0_rd != '0) begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = bus.wb0_rd;
        rf_wdata_d = bus.wb0_data;
      end
    end else if (grant1) begin
      rr_d = 1'b1;
      if (bus.wb1_rd != '0) begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = bus.wb1_rd;
        rf_wdata_d = bus.wb1_data;
      end
    end

    // Clear before set so a same-edge set of the committing reg wins
    if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
    if (accept && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= 1'b1;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rr_q       <= rr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.issue_stall = stall;
  assign bus.wb0_ready   = grant0;
  assign bus.wb1_ready   = grant1;
  assign bus.rf_wen      = rf_wen_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.busy_vec    = busy_q;

endmodule

// File: tb/tb_ysyx_23060096_rf_wb_scheduler.sv
// Directed scenarios plus randomized traffic checked against a behavioural
// scoreboard/arbiter model of the write-back scheduler.
module tb_ysyx_23060096_rf_wb_scheduler;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060096_rf_wb_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREG(NR)) bus ();

  ysyx_23060096_rf_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREG(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: set of pending regs, last winner, expected RF write
  logic [31:0] m_busy;
  int          m_last;
  bit          m_wen;
  int          m_waddr;
  logic [31:0] m_wdata;
  bit          m_stall;
  int          m_g;
  // Inputs applied this cycle
  bit          s_iv, s_v0, s_v1;
  int          s_rd, s_rd0, s_rd1;
  logic [31:0] s_d0, s_d1;

  task automatic model_reset();
    m_busy  = '0;
    m_last  = 1;
    m_wen   = 1'b0;
    m_waddr = 0;
    m_wdata = '0;
  endtask

  function automatic bit is_busy(input int r);
    return (r != 0) && m_busy[r];
  endfunction

  // Apply inputs, then check combinational outputs against the model
  task automatic drive(input bit iv, input int rd, input int rs1, input int rs2,
                       input bit v0, input int rd0, input logic [31:0] d0,
                       input bit v1, input int rd1, input logic [31:0] d1);
    bus.issue_valid = iv;
    bus.issue_rd    = 5'(rd);
    bus.issue_rs1   = 5'(rs1);
    bus.issue_rs2   = 5'(rs2);
    bus.wb0_valid   = v0;
    bus.wb0_rd      = 5'(rd0);
    bus.wb0_data    = d0;
    bus.wb1_valid   = v1;
    bus.wb1_rd      = 5'(rd1);
    bus.wb1_data    = d1;
    s_iv = iv; s_rd = rd; s_v0 = v0; s_rd0 = rd0; s_d0 = d0;
    s_v1 = v1; s_rd1 = rd1; s_d1 = d1;
    #1;
    m_stall = iv && (is_busy(rs1) || is_busy(rs2) || is_busy(rd));
    if (v0 && v1)  m_g = (m_last == 0) ? 1 : 0;
    else if (v0)   m_g = 0;
    else if (v1)   m_g = 1;
    else           m_g = -1;
    check_val("issue_stall", bus.issue_stall, m_stall);
    check_val("wb0_ready", bus.wb0_ready, (m_g == 0));
    check_val("wb1_ready", bus.wb1_ready, (m_g == 1));
  endtask

  // Clock edge: advance the model, then check registered outputs
  task automatic edge_step();
    logic [31:0] nb;
    @(posedge clk);
    nb = m_busy;
    if (m_wen) nb[m_waddr] = 1'b0;
    if (s_iv && !m_stall && s_rd != 0) nb[s_rd] = 1'b1;
    nb[0] = 1'b0;
    m_busy = nb;
    m_wen = 1'b0;
    if (m_g == 0) begin
      m_last = 0;
      if (s_rd0 != 0) begin m_wen = 1'b1; m_waddr = s_rd0; m_wdata = s_d0; end
    end else if (m_g == 1) begin
      m_last = 1;
      if (s_rd1 != 0) begin m_wen = 1'b1; m_waddr = s_rd1; m_wdata = s_d1; end
    end
    @(negedge clk);
    check_val("rf_wen", bus.rf_wen, m_wen);
    check_val("busy_vec", bus.busy_vec, m_busy);
    if (m_wen) begin
      check_val("rf_waddr", bus.rf_waddr, 64'(m_waddr));
      check_val("rf_wdata", bus.rf_wdata, m_wdata);
    end
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    bus.wb0_valid = 1'b0; bus.wb0_rd = '0; bus.wb0_data = '0;
    bus.wb1_valid = 1'b0; bus.wb1_rd = '0; bus.wb1_data = '0;
  endtask

  // Reset while clk is low: effect must be visible before any edge
  task automatic do_reset(input string tag);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check_val({tag, "_rf_wen"}, bus.rf_wen, 0);
    check_val({tag, "_busy"}, bus.busy_vec, 0);
    check_val({tag, "_waddr"}, bus.rf_waddr, 0);
    check_val({tag, "_wdata"}, bus.rf_wdata, 0);
    check_val({tag, "_ready0"}, bus.wb0_ready, 0);
    check_val({tag, "_ready1"}, bus.wb1_ready, 0);
    check_val({tag, "_stall"}, bus.issue_stall, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  bit          p0_v, p1_v;
  int          p0_rd, p1_rd;
  logic [31:0] p0_d, p1_d;
  logic [31:0] saved_busy;

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #3;
    check_val("init_rf_wen", bus.rf_wen, 0);
    check_val("init_busy", bus.busy_vec, 0);
    @(negedge clk);
    rst = 1'b0;

    // RAW on rd=5 through an EXU write-back
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("t2_accept", bus.issue_stall, 0);
    edge_step();
    check_val("t2_busy5_set", bus.busy_vec[5], 1);
    drive(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    check_val("t2_raw_stall", bus.issue_stall, 1);
    edge_step();
    drive(1, 0, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    check_val("t2_grant0", bus.wb0_ready, 1);
    edge_step();
    check_val("t2_wen", bus.rf_wen, 1);
    check_val("t2_waddr", bus.rf_waddr, 5);
    check_val("t2_wdata", bus.rf_wdata, 32'hDEADBEEF);
    drive(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    check_val("t2_no_fwd_stall", bus.issue_stall, 1);
    edge_step();
    check_val("t2_busy5_clr", bus.busy_vec[5], 0);
    drive(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    check_val("t2_stall_gone", bus.issue_stall, 0);
    edge_step();

    // Reset with a write in flight and a busy bit set
    drive(1, 9, 0, 0, 0, 0, 0, 1, 12, 32'h55);
    edge_step();
    check_val("t1_pre_wen", bus.rf_wen, 1);
    do_reset("t1");

    // Both requesters every cycle: strict alternation starting with wb0
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 1, 3, 32'h3333, 1, 4, 32'h4444);
      check_val("t3_alt0", bus.wb0_ready, (i % 2 == 0));
      check_val("t3_alt1", bus.wb1_ready, (i % 2 == 1));
      edge_step();
      check_val("t3_waddr", bus.rf_waddr, (i % 2 == 0) ? 3 : 4);
    end

    // Write-back to x0 is acknowledged but never written
    saved_busy = bus.busy_vec;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234);
    check_val("t4_ready1", bus.wb1_ready, 1);
    edge_step();
    check_val("t4_no_wen", bus.rf_wen, 0);
    check_val("t4_busy_same", bus.busy_vec, saved_busy);

    // Issue rd=7 on the edge that commits rd=7: set wins
    drive(0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0);
    edge_step();
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("t5_accept", bus.issue_stall, 0);
    edge_step();
    check_val("t5_busy7", bus.busy_vec[7], 1);

    // Fill the scoreboard, then an all-x0 instruction must pass
    for (int r = 1; r < 32; r++) begin
      drive(1, r, 0, 0, 0, 0, 0, 0, 0, 0);
      edge_step();
    end
    check_val("t6_all_busy", bus.busy_vec, 32'hFFFF_FFFE);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_val("t6_x0_nostall", bus.issue_stall, 0);
    edge_step();
    check_val("t6_busy0", bus.busy_vec[0], 0);

    // Randomized traffic; requesters hold rd/data until granted
    p0_v = 0; p1_v = 0; p0_rd = 0; p1_rd = 0; p0_d = '0; p1_d = '0;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        do_reset("rnd_rst");
        p0_v = 0; p1_v = 0;
      end
      if (!p0_v && ($urandom_range(0, 2) != 0)) begin
        p0_v = 1; p0_rd = int'($urandom_range(0, 31)); p0_d = $urandom;
      end
      if (!p1_v && ($urandom_range(0, 2) != 0)) begin
        p1_v = 1; p1_rd = int'($urandom_range(0, 31)); p1_d = $urandom;
      end
      drive($urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            p0_v, p0_rd, p0_d, p1_v, p1_rd, p1_d);
      edge_step();
      if (m_g == 0) p0_v = 0;
      if (m_g == 1) p1_v = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
